fetch_queue: RTL and testbench

- Decoupling buffer between the fetch stage and the decode stage.
- Holds up to DEPTH fetched entries, each {instr, pc_plus_4}.
- Presents the oldest entry to decode in first-word-fall-through order.
- Flushed wholesale on any control-flow redirect (taken branch, j/jal, jr).
- Replaces the single IF/ID register, so that decode stalls need not freeze the PC every cycle.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/fetch_queue_storage.sv | 35 +++
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared constants and types for the fetch/decode pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // Default instruction / PC width
    localparam int FQ_WIDTH = 32;

    // sll $0,$0,0 - architectural no-op presented to decode when nothing is queued
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // One queued fetch result
    typedef struct packed {
        logic [FQ_WIDTH-1:0] instr;
        logic [FQ_WIDTH-1:0] pc_plus_4;
    } fq_entry_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/fetch_queue_storage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_storage
// Description : DEPTH x DATA_W register array, one write port and one
//               combinational read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_storage
    import pipeline_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 2 * FQ_WIDTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write the addressed slot; no reset since occupancy is tracked elsewhere
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fetch_queue_storage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : FWFT decoupling queue between fetch and decode. Holds
//               {instr, pc_plus_4} entries, flushed wholesale on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FQ_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           instr_in,
    input  logic [WIDTH-1:0]           pc_plus_4_in,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           instr_out,
    output logic [WIDTH-1:0]           pc_plus_4_out,
    output logic                       valid_out,
    output logic                       full,
    output logic                       stall_f,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               w_pop_eff;
    logic               w_push_acc;
    logic [2*WIDTH-1:0] w_rdata;

    // A pop on an empty queue does nothing; a push at full only fits if the
    // head leaves in the same cycle.
    assign w_pop_eff  = pop & (count_q != '0);
    assign w_push_acc = push & ((count_q != C_DEPTH) | w_pop_eff);

    // Next-state pointers and occupancy; a redirect discards everything,
    // including a same-cycle wrong-path push.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(w_pop_eff);
            tail_d  = tail_q + PW'(w_push_acc);
            count_d = count_q + CW'(w_push_acc) - CW'(w_pop_eff);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fetch_queue_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * WIDTH)
    ) u_storage (
        .clk   (clk),
        .we    (w_push_acc & ~flush & ~reset),
        .waddr (tail_q),
        .wdata ({instr_in, pc_plus_4_in}),
        .raddr (head_q),
        .rdata (w_rdata)
    );

    // Head presentation: forced to NOP/0 when empty so stale storage never leaks
    always_comb begin
        valid_out     = (count_q != '0);
        instr_out     = WIDTH'(NOP_INSTR);
        pc_plus_4_out = '0;
        if (count_q != '0) begin
            instr_out     = w_rdata[2*WIDTH-1:WIDTH];
            pc_plus_4_out = w_rdata[WIDTH-1:0];
        end
    end

    assign full    = (count_q == C_DEPTH);
    assign stall_f = full & ~pop;   // draining a full queue lets fetch proceed
    assign count   = count_q;

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue with a reference queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [31:0] instr_in;
    logic [31:0] pc_plus_4_in;
    logic        pop;
    logic        flush;
    logic [31:0] instr_out;
    logic [31:0] pc_plus_4_out;
    logic        valid_out;
    logic        full;
    logic        stall_f;
    logic [2:0]  count;

    int n_assert = 0;
    int n_fail   = 0;

    fq_entry_t model[$];

    fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .instr_in      (instr_in),
        .pc_plus_4_in  (pc_plus_4_in),
        .pop           (pop),
        .flush         (flush),
        .instr_out     (instr_out),
        .pc_plus_4_out (pc_plus_4_out),
        .valid_out     (valid_out),
        .full          (full),
        .stall_f       (stall_f),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs. Head and stall are checked against the
    // model before the edge; the model then advances and count is checked.
    task automatic cyc(input logic p, input logic [31:0] i, input logic [31:0] pc,
                       input logic po, input logic f);
        bit pe, pa;
        fq_entry_t e;
        push = p; instr_in = i; pc_plus_4_in = pc; pop = po; flush = f;
        #1;
        if (model.size() > 0)
            chk("head", {valid_out, instr_out, pc_plus_4_out}, {1'b1, model[0]});
        else
            chk("head_empty", {valid_out, instr_out, pc_plus_4_out}, 65'h0);
        chk("stall_f", stall_f, (model.size() == 4) && !po);
        @(posedge clk);
        #1;
        if (f) begin
            model.delete();
        end else begin
            pe = po && (model.size() > 0);
            pa = p && ((model.size() < 4) || pe);
            if (pe) void'(model.pop_front());
            if (pa) begin
                e.instr = i; e.pc_plus_4 = pc;
                model.push_back(e);
            end
        end
        push = 1'b0; pop = 1'b0; flush = 1'b0;
        chk("count", count, model.size());
        chk("count_le_4", count <= 3'd4, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model.delete();
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
        instr_in = '0; pc_plus_4_in = '0;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        chk("rst_outs", {valid_out, full, stall_f, count, instr_out, pc_plus_4_out}, 70'h0);

        // 1: three pushes, no pop
        cyc(1, 32'h2008_0001, 32'h4, 0, 0);
        chk("first_push_visible", {valid_out, instr_out}, {1'b1, 32'h2008_0001});
        cyc(1, 32'h2009_0002, 32'h8, 0, 0);
        cyc(1, 32'h200A_0003, 32'hC, 0, 0);
        chk("t1_count", count, 3'd3);
        chk("t1_head", {valid_out, instr_out, pc_plus_4_out}, {1'b1, 32'h2008_0001, 32'h4});

        // 2: fill, push at full is dropped, then pass-through across the wrap
        cyc(1, 32'h200B_0004, 32'h10, 0, 0);
        chk("t2_full", {full, count}, {1'b1, 3'd4});
        push = 1'b1; #1;
        chk("t2_stall", stall_f, 1'b1);
        cyc(1, 32'hDEAD_0005, 32'h14, 0, 0);
        chk("t2_dropped", count, 3'd4);
        for (int k = 0; k < 6; k++) begin
            pop = 1'b1; #1;
            chk("t2_stall_drain", stall_f, 1'b0);
            cyc(1, 32'h3000_0000 + k, 32'h100 + 4 * k, 1, 0);
            chk("t2_count_hold", count, 3'd4);
        end
        // head now is the 3rd of the pass-through entries (k=2)
        chk("t2_order", {instr_out, pc_plus_4_out}, {32'h3000_0002, 32'h108});

        // 3: flush with push and pop, from 3 entries
        cyc(0, 0, 0, 1, 0);
        chk("t3_pre", count, 3'd3);
        cyc(1, 32'hBAD0_0001, 32'h200, 1, 1);
        chk("t3_flushed", {valid_out, count, instr_out, pc_plus_4_out}, 68'h0);

        // 4: pop while empty, then push+pop while empty
        cyc(0, 0, 0, 1, 0);
        chk("t4_pop_empty", count, 3'd0);
        cyc(1, 32'h2010_0010, 32'h40, 1, 0);
        chk("t4_pushpop_empty", {count, valid_out, instr_out, pc_plus_4_out},
            {3'd1, 1'b1, 32'h2010_0010, 32'h40});

        // 5: reset with two entries queued
        cyc(1, 32'h2011_0011, 32'h44, 0, 0);
        chk("t5_pre", count, 3'd2);
        do_reset();
        chk("t5_reset", {valid_out, count, instr_out, pc_plus_4_out}, 68'h0);
        cyc(1, 32'h2012_0012, 32'h48, 0, 0);
        chk("t5_first_push", {count, instr_out, pc_plus_4_out}, {3'd1, 32'h2012_0012, 32'h48});

        // 6: random traffic against the model
        for (int n = 0; n < 1000; n++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 1)), $urandom_range(0, 99) < 5);
        end
        // drain and verify remaining entries in order
        for (int n = 0; n < 5; n++) cyc(0, 0, 0, 1, 0);
        chk("final_empty", {valid_out, count}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
